sel_arb_2to1: RTL and testbench
===============================

# sel_arb_2to1

Two-source round-robin arbiter feeding the 2:1 select datapath: accepts W-bit words from sources A and B over valid/ready handshakes, drives the mux select `sel`, and registers the selected word into a single output stage with its own valid/ready handshake. It sits directly upstream of the consumer of the muxed word and owns all select sequencing, so the mux itself stays purely combinational.

## Interface
- `W`, 2: data width of each source and of the output.
- `BURST_LEN`, 4: maximum consecutive transfers granted to one source while the other is requesting; legal range 1..15.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `a_valid`  in  1  source A has a word.
- `a_data`  in  W  source A word.
- `a_ready`  out  1  A word accepted at this edge when `a_valid & a_ready`.
- `b_valid`  in  1  source B has a word.
- `b_data`  in  W  source B word.
- `b_ready`  out  1  B word accepted at this edge when `b_valid & b_ready`.
- `sel`  out  1  current grant: 0 = A, 1 = B; registered.
- `y_valid`  out  1  output word valid.
- `y_data`  out  W  output word.
- `y_ready`  in  1  consumer accepts at this edge when `y_valid & y_ready`.

## Operation
- FSM states: IDLE, GNT_A, GNT_B. `sel` = 1 in GNT_B; 0 in GNT_A; in IDLE `sel` holds its last value.
- `last` register records the most recently granted source; a reset value of B gives A first priority.
- IDLE: both valid -> grant the source != `last`; one valid -> grant that one; none -> stay.
- `a_ready` = GNT_A & (!`y_valid` | `y_ready`); `b_ready` is symmetric for GNT_B. Both are 0 in IDLE.
- Accepted word is loaded into `y_data` and `y_valid` is set at the same edge. When `y_valid` is high and `y_ready` is low, `y_data` and `y_valid` hold. When the output drains with no new accept, `y_valid` clears.
- Burst counter `cnt` (width $clog2(BURST_LEN+1)) increments per accepted transfer in a grant state and clears on every grant change or entry to IDLE.
- Leaving GNT_X, where Y is the other source:
  - Accept with `cnt+1 == BURST_LEN`: if Y is valid, go to GNT_Y; else if X is valid, stay in GNT_X with `cnt` = 0; else go to IDLE.
  - No accept because X is not valid: if Y is valid, go to GNT_Y; else go to IDLE.
  - No accept because of output backpressure: hold state and `cnt`.
- Sources must hold valid and data stable until accepted. The block does not check this.
- Reset values: state IDLE, `last` = B, `cnt` = 0, `sel` = 0, `y_valid` = 0, `y_data` = 0, `a_ready` = `b_ready` = 0.

## Timing
- Grant latency: a request seen in IDLE at cycle n produces the grant state and ready at cycle n+1.
- Data latency: an accept at the end of cycle n gives `y_valid` and `y_data` at cycle n+1.
- Throughput: one word per cycle while `y_ready` = 1. A grant switch directly between GNT_A and GNT_B costs no bubble. Passing through IDLE costs one cycle.
- A simultaneous output drain and new accept within one cycle replaces `y_data` with no bubble.
- Reset asserted mid-transfer: the in-flight output word is dropped, and all outputs return to reset values at that edge.

## Configuration
- `SEL_ARB_BURST_EN` defined: burst grants up to `BURST_LEN`, as described above.
- `SEL_ARB_BURST_EN` undefined: the effective burst length is fixed at 1. `cnt` is removed, and the grant alternates after every transfer whenever both sources are valid. `BURST_LEN` is ignored.

## Structure
- Package `sel_arb_pkg` holds the state enum `sel_arb_state_t` (IDLE, GNT_A, GNT_B) and the constants `SEL_A` = 1'b0 and `SEL_B` = 1'b1.
- Sub-module `sel_arb_mux2`: a combinational W-bit 2:1 mux of `a_data`/`b_data` under `sel`, whose output feeds the output register load.

## Test plan
- Reset, then A only valid with data 2'b01, 2'b10, `y_ready` = 1: grant at cycle 1; `y_data` = 01 then 10 on consecutive cycles; `sel` stays 0.
- Both valid continuously, `BURST_LEN` = 4, `SEL_ARB_BURST_EN` defined: the output shows four A words, then four B words, with no bubbles; `sel` toggles after every fourth accept.
- Same stimulus with the macro undefined: `y_data` strictly alternates A, B, A, B; `sel` toggles every cycle.
- `y_ready` = 0 for 3 cycles with `y_valid` = 1: `y_data` is stable, `a_ready` = 0, and `cnt` is unchanged. When `y_ready` rises, transfers resume and the burst completes with the correct count.
- In GNT_A, A drops valid while B is valid: next cycle `sel` = 1 and `b_ready` = 1. With B also low, the state goes to IDLE and both readies are 0.
- `rst_n` = 0 while `y_valid` = 1 in GNT_B: at the next edge `y_valid` = 0, `sel` = 0, and state is IDLE. With both valid after reset, A is granted first.

Source files
------------

// File: rtl/sel_arb_pkg.sv
// Shared types and constants for the two-source round-robin select arbiter.
//   sel_arb_state_t : arbiter FSM state (IDLE, GNT_A, GNT_B)
//   SEL_A / SEL_B   : mux select encodings for source A and source B
package sel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } sel_arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/sel_arb_mux2.sv
// Combinational W-bit 2:1 select mux feeding the arbiter output register.
// Ports:
//   a_i   : word from source A (selected when sel_i = SEL_A)
//   b_i   : word from source B (selected when sel_i = SEL_B)
//   sel_i : select
//   y_o   : selected word
module sel_arb_mux2
  import sel_arb_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  assign y_o = (sel_i == SEL_B) ? b_i : a_i;

endmodule

// File: rtl/sel_arb_2to1.sv
// Two-source round-robin arbiter driving a 2:1 select mux and a single
// registered output stage with valid/ready handshakes.
// Optional feature: define SEL_ARB_BURST_EN to allow up to BURST_LEN
// consecutive transfers per grant; otherwise the grant alternates after
// every transfer whenever both sources request.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   a_valid/a_data   : source A request and word;  a_ready accepts it
//   b_valid/b_data   : source B request and word;  b_ready accepts it
//   sel              : registered grant (0 = A, 1 = B), holds in IDLE
//   y_valid/y_data   : registered output word;     y_ready drains it
module sel_arb_2to1
  import sel_arb_pkg::*;
#(
  parameter int unsigned W         = 2,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  output logic         b_ready,
  output logic         sel,
  output logic         y_valid,
  output logic [W-1:0] y_data,
  input  logic         y_ready
);

  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
    $error("sel_arb_2to1: BURST_LEN must be in 1..15");
  end

  sel_arb_state_t state_q, state_d;
  logic           last_q, last_d;
  logic           sel_q, sel_d;
  logic           y_valid_q, y_valid_d;
  logic [W-1:0]   y_data_q, y_data_d;
  logic [W-1:0]   mux_y;
  logic           a_rdy_c, b_rdy_c;
  logic           accept_c;
  logic           burst_done_c;

`ifdef SEL_ARB_BURST_EN
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign burst_done_c = ((cnt_q + CNT_W'(1)) == CNT_W'(BURST_LEN));
`else
  assign burst_done_c = 1'b1;
`endif

  // Output comb: a source may hand over a word only while granted and the
  // output stage is empty or draining this cycle.
  always_comb begin
    a_rdy_c = 1'b0;
    b_rdy_c = 1'b0;
    if (!y_valid_q || y_ready) begin
      a_rdy_c = (state_q == GNT_A);
      b_rdy_c = (state_q == GNT_B);
    end
  end

  assign a_ready  = a_rdy_c;
  assign b_ready  = b_rdy_c;
  assign accept_c = (a_valid & a_rdy_c) | (b_valid & b_rdy_c);

  sel_arb_mux2 #(.W(W)) u_mux (
    .a_i   (a_data),
    .b_i   (b_data),
    .sel_i (sel_q),
    .y_o   (mux_y)
  );

  // Next-state comb: grant sequencing, round-robin priority and burst count.
  always_comb begin
    logic           own_v;
    logic           oth_v;
    sel_arb_state_t oth_st;
    state_d = state_q;
`ifdef SEL_ARB_BURST_EN
    cnt_d   = cnt_q;
`endif
    own_v   = (state_q == GNT_B) ? b_valid : a_valid;
    oth_v   = (state_q == GNT_B) ? a_valid : b_valid;
    oth_st  = (state_q == GNT_B) ? GNT_A : GNT_B;

    unique case (state_q)
      IDLE: begin
        if (a_valid && b_valid) begin
          state_d = (last_q == SEL_A) ? GNT_B : GNT_A;
        end else if (a_valid) begin
          state_d = GNT_A;
        end else if (b_valid) begin
          state_d = GNT_B;
        end
`ifdef SEL_ARB_BURST_EN
        cnt_d = '0;
`endif
      end
      GNT_A, GNT_B: begin
        if (accept_c) begin
          if (burst_done_c) begin
            // Burst spent: hand over if the other side waits, else restart.
            if (oth_v) begin
              state_d = oth_st;
            end else if (!own_v) begin
              state_d = IDLE;
            end
`ifdef SEL_ARB_BURST_EN
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
`endif
          end
        end else if (!own_v) begin
          state_d = oth_v ? oth_st : IDLE;
`ifdef SEL_ARB_BURST_EN
          cnt_d   = '0;
`endif
        end
        // Otherwise stalled by output backpressure: hold state and count.
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // sel and last follow the grant; both hold their value through IDLE.
    last_d = last_q;
    sel_d  = sel_q;
    if (state_d == GNT_A) begin
      last_d = SEL_A;
      sel_d  = SEL_A;
    end else if (state_d == GNT_B) begin
      last_d = SEL_B;
      sel_d  = SEL_B;
    end
  end

  // Output stage: load on accept, clear on drain, otherwise hold.
  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    if (accept_c) begin
      y_valid_d = 1'b1;
      y_data_d  = mux_y;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SEL_B;
      sel_q   <= SEL_A;
`ifdef SEL_ARB_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
`ifdef SEL_ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
    end
  end

  assign sel     = sel_q;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;

endmodule

// File: tb/tb_sel_arb_2to1.sv
// Directed self-checking bench for sel_arb_2to1 (default W = 2, BURST_LEN = 4).
// Expectations adapt to SEL_ARB_BURST_EN through the effective burst length.
module tb_sel_arb_2to1;
  import sel_arb_pkg::*;

  localparam int unsigned W  = 2;
  localparam int unsigned BL = 4;
`ifdef SEL_ARB_BURST_EN
  localparam int unsigned EFF = BL;
`else
  localparam int unsigned EFF = 1;
`endif
  localparam logic [W-1:0] DA = 2'b01;
  localparam logic [W-1:0] DB = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_valid, b_valid, y_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, sel, y_valid;
  logic [W-1:0] y_data;

  int n_checks = 0;
  int n_fail   = 0;

  sel_arb_2to1 #(.W(W), .BURST_LEN(BL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .sel     (sel),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Source of the j-th accepted word when both sources request continuously.
  function automatic logic src_of(input int j);
    return ((j / EFF) % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = '0;
    b_data  = '0;
    y_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, then A only with two words.
    do_reset();
    check("rst_sel", 32'(sel), 32'(0));
    check("rst_y_valid", 32'(y_valid), 32'(0));
    check("rst_y_data", 32'(y_data), 32'(0));
    check("rst_a_ready", 32'(a_ready), 32'(0));
    check("rst_b_ready", 32'(b_ready), 32'(0));
    check("rst_state", 32'(dut.state_q), 32'(IDLE));

    a_valid = 1'b1;
    a_data  = 2'b01;
    #1;
    check("idle_a_ready", 32'(a_ready), 32'(0));
    tick();
    check("t1_grant_a_ready", 32'(a_ready), 32'(1));
    check("t1_grant_sel", 32'(sel), 32'(0));
    tick();
    check("t1_w0_valid", 32'(y_valid), 32'(1));
    check("t1_w0_data", 32'(y_data), 32'(2'b01));
    a_data = 2'b10;
    tick();
    check("t1_w1_valid", 32'(y_valid), 32'(1));
    check("t1_w1_data", 32'(y_data), 32'(2'b10));
    check("t1_w1_sel", 32'(sel), 32'(0));
    a_valid = 1'b0;
    tick();
    check("t1_drain_valid", 32'(y_valid), 32'(0));
    check("t1_idle_a_ready", 32'(a_ready), 32'(0));
    check("t1_idle_state", 32'(dut.state_q), 32'(IDLE));

    // Both sources valid continuously: bursts of EFF words, no bubbles.
    do_reset();
    a_data  = DA;
    b_data  = DB;
    a_valid = 1'b1;
    b_valid = 1'b1;
    tick();
    check("t2_first_sel", 32'(sel), 32'(0));
    check("t2_first_a_ready", 32'(a_ready), 32'(1));
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("t2_valid_%0d", i), 32'(y_valid), 32'(1));
      check($sformatf("t2_data_%0d", i), 32'(y_data), 32'(src_of(i) ? DB : DA));
      check($sformatf("t2_sel_%0d", i), 32'(sel), 32'(src_of(i + 1)));
    end

    // Output backpressure for three cycles in the middle of a burst.
    do_reset();
    a_data  = DA;
    b_data  = DB;
    a_valid = 1'b1;
    b_valid = 1'b1;
    tick();
    tick();
    check("t3_w0_data", 32'(y_data), 32'(DA));
    check("t3_w0_sel", 32'(sel), 32'(src_of(1)));
    y_ready = 1'b0;
    #1;
    check("t3_bp_a_ready", 32'(a_ready), 32'(0));
    check("t3_bp_b_ready", 32'(b_ready), 32'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t3_hold_valid_%0d", k), 32'(y_valid), 32'(1));
      check($sformatf("t3_hold_data_%0d", k), 32'(y_data), 32'(DA));
      check($sformatf("t3_hold_sel_%0d", k), 32'(sel), 32'(src_of(1)));
      check($sformatf("t3_hold_a_ready_%0d", k), 32'(a_ready), 32'(0));
      check($sformatf("t3_hold_b_ready_%0d", k), 32'(b_ready), 32'(0));
`ifdef SEL_ARB_BURST_EN
      check($sformatf("t3_hold_cnt_%0d", k), 32'(dut.cnt_q), 32'(1));
`endif
    end
    y_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      tick();
      check($sformatf("t3_resume_data_%0d", j), 32'(y_data), 32'(src_of(j) ? DB : DA));
      check($sformatf("t3_resume_sel_%0d", j), 32'(sel), 32'(src_of(j + 1)));
    end

    // A drops while granted and B requests, then B drops too.
    do_reset();
    a_data  = DA;
    b_data  = DB;
    a_valid = 1'b1;
    tick();
    check("t4_grant_a", 32'(dut.state_q), 32'(GNT_A));
    a_valid = 1'b0;
    b_valid = 1'b1;
    tick();
    check("t4_switch_sel", 32'(sel), 32'(1));
    check("t4_switch_b_ready", 32'(b_ready), 32'(1));
    check("t4_switch_a_ready", 32'(a_ready), 32'(0));
    check("t4_no_word", 32'(y_valid), 32'(0));
    b_valid = 1'b0;
    tick();
    check("t4_idle_state", 32'(dut.state_q), 32'(IDLE));
    check("t4_idle_a_ready", 32'(a_ready), 32'(0));
    check("t4_idle_b_ready", 32'(b_ready), 32'(0));
    check("t4_idle_sel_hold", 32'(sel), 32'(1));

    // Reset while a B word sits in the output stage.
    b_valid = 1'b1;
    tick();
    check("t5_grant_b", 32'(dut.state_q), 32'(GNT_B));
    tick();
    check("t5_word_valid", 32'(y_valid), 32'(1));
    check("t5_word_data", 32'(y_data), 32'(DB));
    rst_n = 1'b0;
    tick();
    check("t5_rst_y_valid", 32'(y_valid), 32'(0));
    check("t5_rst_y_data", 32'(y_data), 32'(0));
    check("t5_rst_sel", 32'(sel), 32'(0));
    check("t5_rst_state", 32'(dut.state_q), 32'(IDLE));
    check("t5_rst_b_ready", 32'(b_ready), 32'(0));
    rst_n   = 1'b1;
    a_valid = 1'b1;
    tick();
    check("t5_after_sel", 32'(sel), 32'(0));
    check("t5_after_a_ready", 32'(a_ready), 32'(1));
    check("t5_after_b_ready", 32'(b_ready), 32'(0));
    tick();
    check("t5_after_data", 32'(y_data), 32'(DA));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
